uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  8N1 UART transmitter, counterpart of the UART receiver in top. Sends status/echo bytes back to the host.
//  Small internal FIFO decouples producers from the line rate.
//  Bit timing matches the receiver exactly, so one uart_divider value sets both directions.
// PARAMETERS
//  uart_divider  12  prescaler terminal count; bit time = 16*(uart_divider+1) clk cycles
//  fifo_depth    4   FIFO entries; power of two, >=2
// PORTS
//  clk    in   1  system clock; the only clock
//  rst    in   1  reset, asynchronous, active-high
//  data   in   8  byte to send
//  valid  in   1  data valid; transfer on a clk edge where valid && ready
//  ready  out  1  FIFO not full (registered)
//  tx     out  1  serial line, idle high
//  busy   out  1  frame in progress or FIFO non-empty
// BEHAVIOUR
//  Reset (async assert, sync release): tx=1, ready=1, busy=0, FIFO empty, FSM IDLE, counters 0.
//  Reset mid-frame: tx returns high immediately and the frame is abandoned; FIFO contents are dropped.
//  Handshake
//   - ready = !full, from registered count.
//   - Pushes with valid && !ready are ignored; data must be held by the producer.
//   - When full, a pop does not raise ready in the same cycle; ready rises on the next cycle.
//   - Simultaneous push and pop when not full: count unchanged, both take effect.
//  Baud
//   - prescaler counts 0..uart_divider, then 16-step oversample counter; bit ends when both wrap.
//   - Both counters clear on entry to START, so every frame is exactly 10 bit times.
//  FSM
//   - IDLE: tx=1. If FIFO non-empty: pop into shift register and enter START.
//     tx goes low at the clk edge after the accepting edge.
//   - START: tx=0 for 1 bit, then DATA with bit index 0.
//   - DATA: tx=shift[0], LSB first; shift right each bit; after bit index 7, enter STOP.
//   - STOP: tx=1 for 1 full bit.
//     At stop end, if FIFO non-empty, pop and go straight to START (zero idle gap); else IDLE.
//  busy = (state!=IDLE) || !empty; it drops in the same cycle IDLE is re-entered with the FIFO empty.
//  Pointers are log2(fifo_depth) bits and wrap naturally; count is log2(fifo_depth)+1 bits.
// STRUCTURE
//  uart_pkg (shared with the receiver):
//   - UART_OVERSAMPLE=16, UART_DATA_BITS=8
//   - typedef enum logic [1:0] {IDLE,START,DATA,STOP} uart_tx_state_t
//  Sub-module uart_tx_fifo:
//   - synchronous-write, combinational-read register FIFO
//   - ports clk, rst, push, pop, wdata, rdata, full, empty
//  Top-level uart_tx holds the prescaler, oversample and bit counters, FSM and shift register.
// TESTING (uart_divider=12 -> 208 clk/bit, 2080 clk/frame)
//  1 Push 0x41 once -> tx low 208 clk, then bits 1,0,0,0,0,0,1,0, stop high 208 clk; busy low after 2080 clk.
//  2 Push 0x41,0x20,0xC0 back-to-back -> 3 frames, 6240 clk total, no idle gap; loopback into top's receiver decodes all three.
//  3 Hold valid 8 cycles with distinct bytes, depth 4 -> exactly 5 accepted; ready stays low until the first stop completes; bytes emitted in order.
//  4 Assert rst at clk 1000 of a frame -> tx=1 same cycle, busy=0, ready=1; next push sends a clean frame.
//  5 uart_divider=0, push 0xFF -> bit time 16 clk, tx low exactly 16 clk, then high 144 clk.
//  6 valid with ready low, changing data -> no extra byte emitted; FIFO count unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and transmitter FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// Latency: n/a (signal bundle).
// Backpressure: valid/ready; a byte moves on a clk edge where valid && ready.
// Ports: data (byte), valid (producer has a byte), ready (consumer can take it).
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Register FIFO: synchronous write, combinational read of the head entry.
// Latency: a pushed byte is visible on rdata/empty the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty; full/empty come from a registered count.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata, full, empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the count MSB is set exactly when full.
  assign full  = count[AW];
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; bit time is 16*(uart_divider+1) clk.
// Latency: tx falls one clk after the edge that accepts a byte into an idle transmitter.
// Backpressure: bus.ready = FIFO not full; back-to-back frames leave no idle gap.
// Ports: clk, rst (async, active-high), bus (slave byte handshake), tx (serial, idle high), busy.
module uart_tx
  import uart_pkg::*;
#(
  parameter int uart_divider = 12,
  parameter int fifo_depth   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy
);

  localparam int PW = (uart_divider > 0) ? $clog2(uart_divider + 1) : 1;
  localparam int OW = $clog2(UART_OVERSAMPLE);
  localparam int BW = $clog2(UART_DATA_BITS);

  localparam logic [PW-1:0] PRE_LAST = PW'(uart_divider);
  localparam logic [OW-1:0] OS_LAST  = OW'(UART_OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q;
  uart_tx_state_t            state_n;
  logic [PW-1:0]             pre_q;
  logic [OW-1:0]             os_q;
  logic [BW-1:0]             bit_q;
  logic [BW-1:0]             bit_n;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_n;
  logic                      tx_n;
  logic                      bit_end;
  logic                      fifo_pop;
  logic                      clear_baud;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;

  uart_tx_fifo #(
    .DEPTH (fifo_depth),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.valid),
    .pop   (fifo_pop),
    .wdata (bus.data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign bit_end   = (pre_q == PRE_LAST) && (os_q == OS_LAST);

  // Same prescaler/oversample structure as the receiver so one divider serves both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      os_q  <= '0;
    end else if (clear_baud || state_q == IDLE) begin
      pre_q <= '0;
      os_q  <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      os_q  <= os_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
    end else begin
      state_q <= state_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    bit_n      = bit_q;
    shift_n    = shift_q;
    fifo_pop   = 1'b0;
    clear_baud = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_n    = fifo_rdata;
          clear_baud = 1'b1;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (bit_q == BIT_LAST) state_n = STOP;
          else                   bit_n   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_n    = fifo_rdata;
            clear_baud = 1'b1;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state to keep tx glitch-free.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule
